regfile_writeback: RTL and testbench

//  Writeback stage directly upstream of the register file write port (wr_num/wr_data/wr_en).

---
 rtl/regfile_writeback.sv | 219 +++++++++++++++++++++
 tb/tb_regfile_writeback.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// -----------------------------------------------------------------------------
// regfile_writeback
//
// Writeback stage that sits directly in front of the register file write port.
// ALU results take one cycle and load results take a variable number of cycles.
// This stage merges both onto the single write port. Load results are buffered
// in a small FIFO. A pending-write scoreboard lets issue logic stall on RAW
// hazards.
//
// Ports
//   clk         clock, all state updates on the rising edge
//   rst         synchronous active-high reset
//   issue_en    an instruction writing issue_num is issued this cycle
//   issue_num   destination register of the issued instruction
//   alu_valid   ALU result present (alu_num / alu_data)
//   alu_ready   ALU result accepted when alu_valid && alu_ready (registered)
//   mem_valid   load result present (mem_num / mem_data)
//   mem_ready   load result enqueued when mem_valid && mem_ready (registered)
//   wr_num      register file write address (registered)
//   wr_data     register file write data (registered)
//   wr_en       register file write enable (registered, never set for r0)
//   busy        busy[r]=1 while a write to r is outstanding; bit 0 is tied low
//   fifo_count  current load FIFO occupancy, 0..FIFO_DEPTH
// -----------------------------------------------------------------------------
module regfile_writeback #(
  parameter int FIFO_DEPTH   = 4,  // load FIFO entries, power of two, >= 2
  parameter int STARVE_LIMIT = 3   // cycles the FIFO head may wait before the ALU is throttled
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          issue_en,
  input  logic [3:0]                    issue_num,
  input  logic                          alu_valid,
  output logic                          alu_ready,
  input  logic [3:0]                    alu_num,
  input  logic [31:0]                   alu_data,
  input  logic                          mem_valid,
  output logic                          mem_ready,
  input  logic [3:0]                    mem_num,
  input  logic [31:0]                   mem_data,
  output logic [3:0]                    wr_num,
  output logic [31:0]                   wr_data,
  output logic                          wr_en,
  output logic [15:0]                   busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);        // pointer width
  localparam int CW = PW + 1;                    // occupancy width (holds FIFO_DEPTH)
  localparam int SW = $clog2(STARVE_LIMIT + 1);  // starvation counter width

  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // FIFO storage: {num, data}. Not reset; reset only clears the pointers and count.
  logic [35:0]   r_fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic [SW-1:0] r_starve;
  logic          r_alu_ready;
  logic          r_mem_ready;

  logic          r_wr_en;
  logic [3:0]    r_wr_num;
  logic [31:0]   r_wr_data;

  logic [15:0]   r_busy;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic          w_empty;
  logic          w_alu_win;
  logic          w_deq;
  logic          w_enq;
  logic [35:0]   w_head;
  logic [3:0]    w_head_num;
  logic [31:0]   w_head_data;

  assign w_empty     = (r_count == '0);
  // An accepted ALU result always wins. The FIFO head is written only in cycles
  // without an accepted ALU result. The starvation throttle pulls alu_ready
  // low to force such a cycle.
  assign w_alu_win   = alu_valid && r_alu_ready;
  assign w_deq       = !w_alu_win && !w_empty;
  // mem_ready is low while the FIFO is full, so an enqueue never meets a full FIFO.
  assign w_enq       = mem_valid && r_mem_ready;
  assign w_head      = r_fifo_mem[r_rd_ptr];
  assign w_head_num  = w_head[35:32];
  assign w_head_data = w_head[31:0];

  // ---------------------------------------------------------------------------
  // FIFO occupancy and starvation bookkeeping
  // ---------------------------------------------------------------------------
  logic [CW-1:0] w_count_next;
  logic [SW-1:0] w_starve_next;

  always_comb begin
    w_count_next = r_count;
    case ({w_enq, w_deq})
      2'b10:   w_count_next = r_count + CW'(1);
      2'b01:   w_count_next = r_count - CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Counts the cycles in which a waiting head was passed over. The counter
  // saturates at the limit. It cannot go past the limit because the throttle
  // forces a dequeue at that point.
  always_comb begin
    w_starve_next = r_starve;
    if (w_empty || w_deq) begin
      w_starve_next = '0;
    end else if (r_starve != LIMIT_C) begin
      w_starve_next = r_starve + SW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO storage and pointers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_fifo_mem[r_wr_ptr] <= {mem_num, mem_data};
    end
  end

  // Pointers are exactly log2(FIFO_DEPTH) bits wide, so incrementing wraps them
  // modulo the depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_starve    <= '0;
      r_alu_ready <= 1'b1;
      r_mem_ready <= 1'b1;
    end else begin
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count     <= w_count_next;
      r_starve    <= w_starve_next;
      // Both ready flags are registered from next-state values. They always
      // agree with the occupancy and counter shown in the same cycle.
      r_alu_ready <= (w_starve_next < LIMIT_C);
      r_mem_ready <= (w_count_next < DEPTH_C);
    end
  end

  // ---------------------------------------------------------------------------
  // Write port register
  // ---------------------------------------------------------------------------
  // An r0 destination still consumes its slot and updates wr_num/wr_data, but
  // the enable is suppressed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_en   <= 1'b0;
      r_wr_num  <= '0;
      r_wr_data <= '0;
    end else if (w_alu_win) begin
      r_wr_en   <= (alu_num != 4'd0);
      r_wr_num  <= alu_num;
      r_wr_data <= alu_data;
    end else if (w_deq) begin
      r_wr_en   <= (w_head_num != 4'd0);
      r_wr_num  <= w_head_num;
      r_wr_data <= w_head_data;
    end else begin
      r_wr_en   <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  // A write in progress on the port clears its register. A new issue to the
  // same register on the same edge keeps it busy, because the newer
  // instruction is still pending.
  logic [15:0] w_busy_next;

  assign w_busy_next[0] = 1'b0;

  for (genvar gi = 1; gi < 16; gi++) begin : g_busy
    logic w_set;
    logic w_clr;
    assign w_set = issue_en && (issue_num == 4'(gi));
    assign w_clr = r_wr_en && (r_wr_num == 4'(gi));
    assign w_busy_next[gi] = w_set ? 1'b1 : (w_clr ? 1'b0 : r_busy[gi]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign alu_ready  = r_alu_ready;
  assign mem_ready  = r_mem_ready;
  assign wr_en      = r_wr_en;
  assign wr_num     = r_wr_num;
  assign wr_data    = r_wr_data;
  assign busy       = r_busy;
  assign fifo_count = r_count;

endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_en;
  logic [3:0]  issue_num;
  logic        alu_valid;
  logic        alu_ready;
  logic [3:0]  alu_num;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [3:0]  mem_num;
  logic [31:0] mem_data;
  logic [3:0]  wr_num;
  logic [31:0] wr_data;
  logic        wr_en;
  logic [15:0] busy;
  logic [2:0]  fifo_count;

  always #5 clk = ~clk;

  regfile_writeback #(.FIFO_DEPTH(4), .STARVE_LIMIT(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .issue_en   (issue_en),
    .issue_num  (issue_num),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_num    (alu_num),
    .alu_data   (alu_data),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_num    (mem_num),
    .mem_data   (mem_data),
    .wr_num     (wr_num),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  int total = 0;
  int bad   = 0;

  // One cycle of stimulus and the outputs expected after the edge that ends it.
  // chk_wd selects whether wr_num/wr_data are compared.
  typedef struct packed {
    logic        ie;
    logic [3:0]  inum;
    logic        av;
    logic [3:0]  an;
    logic [31:0] ad;
    logic        mv;
    logic [3:0]  mn;
    logic [31:0] md;
    logic        e_wen;
    logic [3:0]  e_wnum;
    logic [31:0] e_wdata;
    logic [15:0] e_busy;
    logic [2:0]  e_cnt;
    logic        e_ar;
    logic        e_mr;
    logic        chk_wd;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(
    input logic ie, input logic [3:0] inum,
    input logic av, input logic [3:0] an, input logic [31:0] ad,
    input logic mv, input logic [3:0] mn, input logic [31:0] md,
    input logic wen, input logic [3:0] wn, input logic [31:0] wd,
    input logic [15:0] b, input logic [2:0] c, input logic ar, input logic mr,
    input logic cw);
    vec_t v;
    v = '{ie, inum, av, an, ad, mv, mn, md, wen, wn, wd, b, c, ar, mr, cw};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(
    input logic ie, input logic [3:0] inum,
    input logic av, input logic [3:0] an, input logic [31:0] ad,
    input logic mv, input logic [3:0] mn, input logic [31:0] md);
    issue_en  = ie;
    issue_num = inum;
    alu_valid = av;
    alu_num   = an;
    alu_data  = ad;
    mem_valid = mv;
    mem_num   = mn;
    mem_data  = md;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(
    input string tag,
    input logic wen, input logic [3:0] wn, input logic [31:0] wd,
    input logic [15:0] b, input logic [2:0] c, input logic ar, input logic mr,
    input logic cw);
    $display("%s: wr_en=%b wr_num=%0d wr_data=%h busy=%h cnt=%0d alu_rdy=%b mem_rdy=%b",
             tag, wr_en, wr_num, wr_data, busy, fifo_count, alu_ready, mem_ready);
    chk({tag, " wr_en"},      32'(wr_en),      32'(wen));
    chk({tag, " busy"},       32'(busy),       32'(b));
    chk({tag, " fifo_count"}, 32'(fifo_count), 32'(c));
    chk({tag, " alu_ready"},  32'(alu_ready),  32'(ar));
    chk({tag, " mem_ready"},  32'(mem_ready),  32'(mr));
    if (cw) begin
      chk({tag, " wr_num"},  32'(wr_num), 32'(wn));
      chk({tag, " wr_data"}, wr_data,     wd);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 4'd0, 1'b1, 4'd5, 32'hCAFE0005, 1'b0, 4'd0, 32'h0);
    step();
    step();
    expect_out("reset", 1'b0, 4'd0, 32'h0, 16'h0, 3'd0, 1'b1, 1'b1, 1'b1);
    rst = 1'b0;
    drive(1'b0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);

    //            ie inum av an     ad            mv mn     md             wen wn     wd            busy      cnt ar mr cw
    vecs[0]  = mk(1, 4'd5, 0, 4'd0, 32'h0,        0, 4'd0, 32'h0,         0, 4'd0, 32'h0,        16'h0020, 0, 1, 1, 0);
    vecs[1]  = mk(0, 4'd0, 1, 4'd5, 32'hDEADBEEF, 0, 4'd0, 32'h0,         1, 4'd5, 32'hDEADBEEF, 16'h0020, 0, 1, 1, 1);
    vecs[2]  = mk(0, 4'd0, 0, 4'd0, 32'h0,        0, 4'd0, 32'h0,         0, 4'd0, 32'h0,        16'h0000, 0, 1, 1, 0);
    vecs[3]  = mk(1, 4'd3, 0, 4'd0, 32'h0,        1, 4'd3, 32'h12345678,  0, 4'd0, 32'h0,        16'h0008, 1, 1, 1, 0);
    vecs[4]  = mk(0, 4'd0, 0, 4'd0, 32'h0,        0, 4'd0, 32'h0,         1, 4'd3, 32'h12345678, 16'h0008, 0, 1, 1, 1);
    vecs[5]  = mk(1, 4'd9, 0, 4'd0, 32'h0,        0, 4'd0, 32'h0,         0, 4'd0, 32'h0,        16'h0200, 0, 1, 1, 0);
    vecs[6]  = mk(0, 4'd0, 1, 4'd0, 32'h11110000, 0, 4'd0, 32'h0,         0, 4'd0, 32'h11110000, 16'h0200, 0, 1, 1, 1);
    vecs[7]  = mk(0, 4'd0, 0, 4'd0, 32'h0,        0, 4'd0, 32'h0,         0, 4'd0, 32'h0,        16'h0200, 0, 1, 1, 0);
    vecs[8]  = mk(0, 4'd0, 1, 4'd9, 32'h22222222, 0, 4'd0, 32'h0,         1, 4'd9, 32'h22222222, 16'h0200, 0, 1, 1, 1);
    vecs[9]  = mk(1, 4'd9, 0, 4'd0, 32'h0,        0, 4'd0, 32'h0,         0, 4'd0, 32'h0,        16'h0200, 0, 1, 1, 0);
    vecs[10] = mk(0, 4'd0, 1, 4'd9, 32'h33333333, 0, 4'd0, 32'h0,         1, 4'd9, 32'h33333333, 16'h0200, 0, 1, 1, 1);
    vecs[11] = mk(0, 4'd0, 0, 4'd0, 32'h0,        0, 4'd0, 32'h0,         0, 4'd0, 32'h0,        16'h0000, 0, 1, 1, 0);
    vecs[12] = mk(0, 4'd0, 1, 4'd4, 32'h44444444, 1, 4'd6, 32'h66666666,  1, 4'd4, 32'h44444444, 16'h0000, 1, 1, 1, 1);
    vecs[13] = mk(0, 4'd0, 1, 4'd1, 32'h01010101, 0, 4'd0, 32'h0,         1, 4'd1, 32'h01010101, 16'h0000, 1, 1, 1, 1);
    vecs[14] = mk(0, 4'd0, 0, 4'd0, 32'h0,        0, 4'd0, 32'h0,         1, 4'd6, 32'h66666666, 16'h0000, 0, 1, 1, 1);
    vecs[15] = mk(0, 4'd0, 0, 4'd0, 32'h0,        0, 4'd0, 32'h0,         0, 4'd0, 32'h0,        16'h0000, 0, 1, 1, 0);
    vecs[16] = mk(0, 4'd0, 0, 4'd0, 32'h0,        1, 4'd0, 32'h0F0F0F0F,  0, 4'd0, 32'h0,        16'h0000, 1, 1, 1, 0);
    vecs[17] = mk(0, 4'd0, 0, 4'd0, 32'h0,        0, 4'd0, 32'h0,         0, 4'd0, 32'h0F0F0F0F, 16'h0000, 0, 1, 1, 1);

    // Reset held two cycles while an ALU result is offered
    do_reset();

    // Directed table: ALU write, load path, r0 suppression, set-wins collision
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].ie, vecs[i].inum, vecs[i].av, vecs[i].an, vecs[i].ad,
            vecs[i].mv, vecs[i].mn, vecs[i].md);
      step();
      expect_out($sformatf("vec%0d", i), vecs[i].e_wen, vecs[i].e_wnum, vecs[i].e_wdata,
                 vecs[i].e_busy, vecs[i].e_cnt, vecs[i].e_ar, vecs[i].e_mr, vecs[i].chk_wd);
    end

    // Full FIFO: four loads while the ALU is offered every cycle
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 4'd0, 1'b1, 4'd1, 32'hA0000001, 1'b1, 4'(10 + i), 32'h10000000 + 32'(10 + i));
      step();
      expect_out($sformatf("full_enq%0d", i), 1'b1, 4'd1, 32'hA0000001, 16'h0,
                 3'(i + 1), (i < 3), (i < 3), 1'b1);
    end
    // Throttled ALU and held fifth load; the head r10 is written
    drive(1'b0, 4'd0, 1'b1, 4'd1, 32'hA0000001, 1'b1, 4'd14, 32'h1000000E);
    step();
    expect_out("full_hold", 1'b1, 4'd10, 32'h1000000A, 16'h0, 3'd3, 1'b1, 1'b1, 1'b1);
    // ALU accepted again and the fifth load enters the freed slot
    step();
    expect_out("full_enq4", 1'b1, 4'd1, 32'hA0000001, 16'h0, 3'd4, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      expect_out($sformatf("full_drain%0d", i), 1'b1, 4'(11 + i), 32'h10000000 + 32'(11 + i),
                 16'h0, 3'(3 - i), 1'b1, 1'b1, 1'b1);
    end
    step();
    expect_out("full_idle", 1'b0, 4'd0, 32'h0, 16'h0, 3'd0, 1'b1, 1'b1, 1'b0);

    // Starvation: r7 waits behind a continuous ALU stream
    do_reset();
    drive(1'b1, 4'd7, 1'b1, 4'd1, 32'h000000A1, 1'b1, 4'd7, 32'h77777777);
    step();
    expect_out("starve0", 1'b1, 4'd1, 32'h000000A1, 16'h0080, 3'd1, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 4'd0, 1'b1, 4'd1, 32'h000000A1, 1'b0, 4'd0, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      step();
      expect_out($sformatf("starve%0d", i), 1'b1, 4'd1, 32'h000000A1, 16'h0080, 3'd1,
                 (i < 3), 1'b1, 1'b1);
    end
    step();
    expect_out("starve4", 1'b1, 4'd7, 32'h77777777, 16'h0080, 3'd0, 1'b1, 1'b1, 1'b1);
    step();
    expect_out("starve5", 1'b1, 4'd1, 32'h000000A1, 16'h0000, 3'd0, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    step();
    expect_out("starve6", 1'b0, 4'd0, 32'h0, 16'h0000, 3'd0, 1'b1, 1'b1, 1'b0);

    // Reset mid-operation discards queued loads
    drive(1'b0, 4'd0, 1'b1, 4'd1, 32'h000000B1, 1'b1, 4'd2, 32'h000000B2);
    step();
    expect_out("midrst0", 1'b1, 4'd1, 32'h000000B1, 16'h0, 3'd1, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 4'd0, 1'b1, 4'd1, 32'h000000B1, 1'b1, 4'd3, 32'h000000B3);
    step();
    expect_out("midrst1", 1'b1, 4'd1, 32'h000000B1, 16'h0, 3'd2, 1'b1, 1'b1, 1'b1);
    rst = 1'b1;
    drive(1'b0, 4'd0, 1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    step();
    expect_out("midrst2", 1'b0, 4'd0, 32'h0, 16'h0, 3'd0, 1'b1, 1'b1, 1'b1);
    rst = 1'b0;
    step();
    expect_out("midrst3", 1'b0, 4'd0, 32'h0, 16'h0, 3'd0, 1'b1, 1'b1, 1'b1);
    step();
    expect_out("midrst4", 1'b0, 4'd0, 32'h0, 16'h0, 3'd0, 1'b1, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
